// File: rtl/intpol2_d4_out_wr_pkg.sv
// Shared definitions for the x4 interpolator output-side write sequencer:
// FSM encoding, default ratio and the sample-count width helper.
package intpol2_d4_out_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default interpolation ratio is 4 output samples per input sample.
  localparam int RATIO_LOG2 = 2;

  // ilen is DATA_WIDTH+1 bits wide; ilen*RATIO needs log2(RATIO) more bits.
  function automatic int total_width(input int data_width, input int ratio);
    return data_width + 1 + $clog2(ratio);
  endfunction

endpackage

// File: rtl/intpol2_d4_out_wr_if.sv
// Sample stream from the datapath and write port of the output FIFO.
interface intpol2_d4_out_wr_if #(
  parameter int DATA_WIDTH = 32
);
  // s_data is transferred on every rising edge where s_valid && s_ready.
  // s_ready depends only on sequencer registers, never on s_valid; the
  // FIFO is written on every edge where fifo_we is high (only when !fifo_full).
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  fifo_full;
  logic                  fifo_we;
  logic [DATA_WIDTH-1:0] fifo_wdata;

  modport master (
    input  s_data, s_valid, fifo_full,
    output s_ready, fifo_we, fifo_wdata
  );

  modport slave (
    output s_data, s_valid, fifo_full,
    input  s_ready, fifo_we, fifo_wdata
  );

endinterface

// File: rtl/intpol2_d4_out_wr_skid2.sv
// Two-entry skid FIFO: registered head, simultaneous push/pop keeps order.
module intpol2_d4_out_wr_skid2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;

  // mem0 is always the oldest entry; callers never push when full or pop when empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem0 <= '0;
      mem1 <= '0;
      cnt  <= 2'd0;
    end else if (clear) begin
      mem0 <= '0;
      mem1 <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) mem0 <= din;
          else             mem1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            mem0 <= mem1;
            mem1 <= din;
          end else begin
            mem0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = mem0;

endmodule

// File: rtl/intpol2_d4_out_wr.sv
// Output write sequencer: accepts interpolated samples, buffers them in a
// 2-entry skid and writes them to the output FIFO, counting ilen*RATIO writes.
module intpol2_d4_out_wr
  import intpol2_d4_out_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 1 << RATIO_LOG2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clear,
  input  logic                start,
  input  logic [DATA_WIDTH:0] ilen,
  intpol2_d4_out_wr_if.master bus,
  output logic [1:0]          phase,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state
);

  localparam int              R_LOG2     = $clog2(RATIO);
  localparam int              TW         = total_width(DATA_WIDTH, RATIO);
  localparam logic [1:0]      PHASE_MASK = 2'(RATIO - 1);
  localparam logic [TW-1:0]   ONE        = TW'(1);

  state_t                  state;
  state_t                  state_nx;
  logic [TW-1:0]           total;
  logic [TW-1:0]           acc_cnt;
  logic [TW-1:0]           wr_cnt;
  logic [1:0]              skid_cnt;
  logic [DATA_WIDTH-1:0]   skid_head;
  logic                    s_ready_c;
  logic                    we_c;
  logic                    push;
  logic                    pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      state <= ST_IDLE;
    else if (clear) state <= ST_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready_c = 1'b0;
    we_c      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = (ilen != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        busy      = 1'b1;
        s_ready_c = (skid_cnt < 2'd2) && (acc_cnt < total);
        we_c      = (skid_cnt != 2'd0) && !bus.fifo_full;
        // Leave on the final write so done follows it by exactly one cycle.
        if (we_c && (wr_cnt == total - ONE)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign push = s_ready_c && bus.s_valid;
  assign pop  = we_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else if (clear) begin
      total   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            total   <= {ilen, {R_LOG2{1'b0}}};
            acc_cnt <= '0;
            wr_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (push) acc_cnt <= acc_cnt + ONE;
          if (pop)  wr_cnt  <= wr_cnt + ONE;
        end
        ST_DONE: begin
          acc_cnt <= '0;
          wr_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  intpol2_d4_out_wr_skid2 #(
    .W (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (bus.s_data),
    .head  (skid_head),
    .cnt   (skid_cnt)
  );

  assign bus.s_ready    = s_ready_c;
  assign bus.fifo_we    = we_c;
  assign bus.fifo_wdata = skid_head;
  assign phase          = wr_cnt[1:0] & PHASE_MASK;
  assign dbg_state      = state;

endmodule

// File: tb/tb_intpol2_d4_out_wr.sv
// Bench for intpol2_d4_out_wr: cycle-level reference model built on sample
// counts and an expected-data queue, driven by a table of runs plus corner cases.
module tb_intpol2_d4_out_wr;
  import intpol2_d4_out_wr_pkg::*;

  localparam int W      = 32;
  localparam int BUDGET = 3000;

  typedef struct {
    int unsigned ilen;
    int unsigned p_valid;
    int unsigned p_full;
    int          full_lo;
    int          full_hi;
    int          restart_at;
    int          clear_at;
    int          abort_at_wr;
    bit          seq_data;
    int unsigned exp_writes;
    int unsigned exp_dones;
  } run_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         clear;
  logic         start;
  logic [W:0]   ilen;
  logic [1:0]   phase;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  intpol2_d4_out_wr_if #(.DATA_WIDTH(W)) bus ();

  intpol2_d4_out_wr #(.DATA_WIDTH(W), .RATIO(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .start     (start),
    .ilen      (ilen),
    .bus       (bus),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int         checks = 0;
  int         errors = 0;
  bit         m_run, m_done_due;
  longint     m_total, m_acc, m_wr;
  logic [W-1:0] exp_q[$];
  bit         e_ready, e_we;
  bit         need_data;
  bit         seq_mode;
  int unsigned seq_ctr;
  int         st_writes, st_dones, st_accepts, st_done_cyc, cur_cyc;
  bit         last_ready, st_ready_c7;
  logic [W-1:0] wr_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done_due = 0; m_total = 0; m_acc = 0; m_wr = 0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] next_data();
    if (seq_mode) begin
      seq_ctr++;
      return W'(seq_ctr - 1);
    end
    return W'($urandom);
  endfunction

  task automatic check_cycle();
    state_t e_st;
    e_ready = m_run && (m_acc < m_total) && ((m_acc - m_wr) < 2);
    e_we    = m_run && (m_acc != m_wr) && !bus.fifo_full;
    e_st    = m_done_due ? ST_DONE : (m_run ? ST_RUN : ST_IDLE);
    chk("s_ready", bus.s_ready, e_ready);
    chk("fifo_we", bus.fifo_we, e_we);
    chk("busy", busy, m_run);
    chk("done", done, m_done_due);
    chk("phase", phase, m_wr % 4);
    chk("state", dbg_state, e_st);
    if (e_we && bus.fifo_we && exp_q.size() > 0) chk("fifo_wdata", bus.fifo_wdata, exp_q[0]);
    last_ready = bus.s_ready;
    if (bus.fifo_we) begin
      st_writes++;
      wr_log.push_back(bus.fifo_wdata);
    end
    if (done) begin
      st_dones++;
      st_done_cyc = cur_cyc;
    end
    if (bus.s_ready && bus.s_valid) st_accepts++;
  endtask

  task automatic update_model();
    if (clear) begin
      model_reset();
    end else if (m_done_due) begin
      m_done_due = 0; m_acc = 0; m_wr = 0;
    end else if (!m_run) begin
      if (start) begin
        m_total = longint'(ilen) * 4;
        m_acc = 0; m_wr = 0;
        exp_q.delete();
        if (ilen == '0) m_done_due = 1;
        else            m_run = 1;
      end
    end else begin
      if (e_we) begin
        void'(exp_q.pop_front());
        m_wr++;
      end
      if (e_ready && bus.s_valid) begin
        exp_q.push_back(bus.s_data);
        m_acc++;
        need_data = 1;
      end
      if (e_we && m_wr == m_total) begin
        m_run = 0;
        m_done_due = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
    if (need_data) begin
      bus.s_data = next_data();
      need_data  = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
    chk({tag, "_fifo_we"}, bus.fifo_we, 1'b0);
    chk({tag, "_fifo_wdata"}, bus.fifo_wdata, '0);
    chk({tag, "_phase"}, phase, 2'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic idle_cycles(input int n, input bit valid);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = valid;
      tick();
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic run(input run_t c);
    bit ended;
    ended = 0;
    st_writes = 0; st_dones = 0; st_accepts = 0; st_done_cyc = -1;
    st_ready_c7 = 1'b1;
    wr_log.delete();
    seq_mode = c.seq_data;
    seq_ctr  = 1;
    bus.s_data = next_data();
    for (int cyc = 0; cyc < BUDGET && !ended; cyc++) begin
      cur_cyc = cyc;
      start = (cyc == 0) || (cyc == c.restart_at);
      if (cyc == 0)            ilen = {1'b0, c.ilen};
      if (cyc == c.restart_at) ilen = {1'b0, c.ilen + 32'd3};
      clear = (cyc == c.clear_at);
      bus.s_valid   = ($urandom_range(99) < c.p_valid);
      bus.fifo_full = (cyc >= c.full_lo && cyc <= c.full_hi) || ($urandom_range(99) < c.p_full);
      tick();
      if (cyc == 7) st_ready_c7 = last_ready;
      if (st_dones != 0 || cyc == c.clear_at) begin
        ended = 1;
      end else if (c.abort_at_wr >= 0 && st_writes == c.abort_at_wr) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_reset();
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        ended = 1;
      end
    end
    start = 1'b0; clear = 1'b0; bus.s_valid = 1'b0; bus.fifo_full = 1'b0;
    chk("run_ended", ended, 1'b1);
    chk("writes", st_writes, c.exp_writes);
    chk("dones", st_dones, c.exp_dones);
    idle_cycles(2, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  run_t tbl[5];
  run_t r;

  initial begin
    rstn = 1'b0; clear = 1'b0; start = 1'b0; ilen = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.fifo_full = 1'b0;
    need_data = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;

    // Randomized runs: ilen, valid %, full %, expected writes and done pulses.
    tbl[0] = '{1,  70, 30, -1, -1, -1, -1, -1, 0, 4,  1};
    tbl[1] = '{2,  50, 50, -1, -1, -1, -1, -1, 0, 8,  1};
    tbl[2] = '{5, 100,  0, -1, -1, -1, -1, -1, 0, 20, 1};
    tbl[3] = '{16, 30, 60, -1, -1, -1, -1, -1, 0, 64, 1};
    tbl[4] = '{7,  90, 20, -1, -1, -1, -1, -1, 0, 28, 1};
    for (int i = 0; i < 5; i++) run(tbl[i]);

    // Basic run: data 1..12 in order, done the cycle after the 12th write.
    r = '{3, 100, 0, -1, -1, -1, -1, -1, 1, 12, 1};
    run(r);
    for (int i = 0; i < 12 && i < wr_log.size(); i++) chk("basic_data", wr_log[i], 64'(i + 1));
    chk("basic_done_cyc", st_done_cyc, 14);

    // Back-pressure: full during cycles 3..7, skid fills and s_ready drops.
    r = '{2, 100, 0, 3, 7, -1, -1, -1, 1, 8, 1};
    run(r);
    chk("bp_ready_c7", st_ready_c7, 1'b0);
    for (int i = 0; i < 8 && i < wr_log.size(); i++) chk("bp_data", wr_log[i], 64'(i + 1));

    // Zero length: no writes, no acceptances, done one cycle after start.
    r = '{0, 100, 0, -1, -1, -1, -1, -1, 1, 0, 1};
    run(r);
    chk("zero_accepts", st_accepts, 0);
    chk("zero_done_cyc", st_done_cyc, 1);

    // Overflow guard: valid held high, only ilen*4 samples accepted.
    r = '{1, 100, 0, -1, -1, -1, -1, -1, 1, 4, 1};
    run(r);
    idle_cycles(4, 1'b1);
    chk("ovf_accepts", st_accepts, 4);

    // Mid-run reset after 5 writes, then a fresh ilen=1 run.
    r = '{4, 100, 0, -1, -1, -1, -1, 5, 1, 5, 0};
    run(r);
    r = '{1, 100, 0, -1, -1, -1, -1, -1, 1, 4, 1};
    run(r);

    // Synchronous clear mid-run: skid dropped, no done pulse.
    r = '{3, 100, 0, -1, -1, -1, 5, -1, 1, 4, 0};
    run(r);
    r = '{2, 80, 30, -1, -1, -1, -1, -1, 0, 8, 1};
    run(r);

    // Start while busy: ignored, total and done count unchanged.
    r = '{2, 100, 0, -1, -1, 3, -1, -1, 1, 8, 1};
    run(r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_out_wr.md
Name: intpol2_D4_out_wr

Overview:
Output-side write sequencer for the 2nd-order ×4 interpolator. It takes interpolated samples from the datapath over a valid/ready handshake and buffers them in a 2-entry skid buffer. It writes them into the output FIFO under full back-pressure, counts them against ilen×RATIO, and reports busy/done. It is the transmitter counterpart of the input-side read/next-state control.

Parameters:
- DATA_WIDTH, 32, sample width; also sets ilen width (DATA_WIDTH+1).
- RATIO, 4, output samples per input sample; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear; same effect as reset, one cycle.
- start  in  1  one-cycle pulse; latches ilen and starts a run (ignored unless IDLE).
- ilen  in  DATA_WIDTH+1  number of input samples in the run.
- s_data  in  DATA_WIDTH  interpolated sample from datapath.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts s_data this cycle.
- fifo_full  in  1  output FIFO full.
- fifo_we  out  1  write strobe to output FIFO.
- fifo_wdata  out  DATA_WIDTH  write data.
- phase  out  2  wr_cnt mod RATIO (low 2 bits), sub-sample index of the current write.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset/clear values: state=IDLE, skid empty, acc_cnt=wr_cnt=0, total=0. Outputs: s_ready=0, fifo_we=0, fifo_wdata=0, phase=0, busy=0, done=0.
- total = ilen × RATIO, latched on start. Width DATA_WIDTH+1+log2(RATIO), no truncation.
- State IDLE:
  - start with ilen≠0 -> RUN.
  - start with ilen=0 -> DONE with no writes.
- State RUN:
  - s_ready = (skid_cnt<2) && (acc_cnt<total). Combinational from registers only; no dependency on s_valid.
  - Accept when s_valid && s_ready: push into skid, acc_cnt+1.
  - fifo_we = (skid_cnt>0) && !fifo_full. fifo_wdata = skid head (registered).
  - On a write: pop the head, wr_cnt+1.
  - Push and pop in the same cycle: skid_cnt unchanged, order preserved.
  - Minimum latency is 1 cycle from acceptance to fifo_we. Sustained throughput is 1 sample/clk while fifo_full=0.
  - When wr_cnt reaches total -> DONE.
- State DONE: done=1 for exactly one cycle, busy=0 from the next cycle, -> IDLE.
- busy = 1 in RUN; 0 in IDLE and after DONE.
- phase = wr_cnt[1:0] (RATIO=4); it follows the sample being presented on fifo_wdata.
- fifo_full asserted: fifo_we=0, skid holds. s_ready drops only when the skid holds 2 entries.
- Datapath samples beyond total are never accepted (s_ready=0 once acc_cnt=total).
- start while busy: ignored.
- clear/reset mid-run: skid contents discarded, counters zeroed, no done pulse.
- fifo_we is never asserted with the skid empty.
- wr_cnt never exceeds acc_cnt, and acc_cnt never exceeds total.

Decomposition:
- Shared package intpol2_D4_pkg:
  - state encoding: IDLE/RUN/DONE.
  - RATIO_LOG2 constant.
  - helper function for the total-count width.
- Sub-module intpol2_D4_skid2:
  - 2-entry skid FIFO (push, pop, head, cnt).
  - reused for any later datapath back-pressure stage.
- Top holds the FSM, the counters and the handshake glue.

Test Plan:
- Basic run: ilen=3, s_valid always 1, fifo_full=0, s_data=1..12.
  - Exactly 12 fifo_we pulses with data 1..12 in order.
  - phase sequence 0,1,2,3 repeating.
  - One done pulse the cycle after the 12th write; busy low afterwards.
- Back-pressure: ilen=2, fifo_full=1 for cycles 3-7.
  - No writes while full; skid fills to 2 and s_ready=0.
  - After release, the 8 samples come out in order, none lost or duplicated.
- Zero length: start with ilen=0.
  - No fifo_we, s_ready never 1.
  - done one cycle after start, then IDLE.
- Overflow guard: ilen=1, s_valid held high for 10 cycles.
  - Exactly 4 acceptances; s_ready=0 thereafter; 4 writes.
- Mid-run reset: rstn low after 5 writes of an ilen=4 run.
  - All outputs return to reset values immediately, no done pulse.
  - A new run with ilen=1 then produces exactly 4 writes.
- Start while busy: second start during RUN.
  - Ignored; total unchanged; done count = 1.
